// File: rtl/uart_packet_decoder.sv
// uart_packet_decoder
//   Turns the raw, unstallable UART byte stream into a valid/ready payload
//   stream for the DMA byte port. Each packet is MAGIC, len[15:8], len[7:0],
//   then len payload bytes. The header is stripped; the payload goes through
//   a small FIFO and the final payload byte is flagged with out_last.
//
// Ports
//   clock       system clock, all state on the rising edge
//   clear_n     asynchronous active-low reset
//   uart_valid  one-cycle strobe, uart_data holds a received byte
//   uart_data   received byte
//   out_valid   FIFO head valid
//   out_data    FIFO head byte (0 while empty)
//   out_last    FIFO head is the final payload byte of its packet
//   out_ready   downstream accept
//   overflow    sticky: a payload byte was dropped because the FIFO was full
//   drop_count  saturating count of discarded header/garbage bytes
module uart_packet_decoder #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] MAGIC      = 8'h55
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic       uart_valid,
    input  logic [7:0] uart_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       overflow,
    output logic [7:0] drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LEN_HI, LEN_LO, PAYLOAD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_hi_q, len_hi_d;
    logic [15:0]   remaining_q, remaining_d;
    logic          pending_q, pending_d;
    logic          overflow_q;
    logic [7:0]    drop_count_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [8:0]    mem [FIFO_DEPTH];

    logic          fifo_full, filler, push, pop, drop, ovf_set;
    logic [8:0]    push_word, head;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign fifo_full = (count_q == FULL_COUNT);
    // A lost final byte is owed to the DMA as a filler entry; it wins the
    // first free slot, ahead of any UART byte arriving that cycle.
    assign filler    = pending_q && !fifo_full;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        remaining_d = remaining_q;
        pending_d   = pending_q;
        push        = 1'b0;
        push_word   = 9'h000;
        drop        = 1'b0;
        ovf_set     = 1'b0;

        if (filler) begin
            push      = 1'b1;
            push_word = {1'b1, 8'h00};
            pending_d = 1'b0;
        end

        if (uart_valid) begin
            // A UART byte colliding with the filler push is lost.
            if (filler) begin
                ovf_set = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (!filler) begin
                        if (uart_data == MAGIC) begin
                            state_d = LEN_HI;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                LEN_HI: begin
                    if (!filler) begin
                        len_hi_d = uart_data;
                        state_d  = LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (!filler) begin
                        if ({len_hi_q, uart_data} == 16'd0) begin
                            state_d = IDLE;
                            drop    = 1'b1;
                        end else begin
                            remaining_d = {len_hi_q, uart_data};
                            state_d     = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    // Framing advances even when the byte is dropped so the
                    // next header is still found.
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = IDLE;
                    end
                    if (filler || fifo_full) begin
                        ovf_set = 1'b1;
                        if (remaining_q == 16'd1) begin
                            pending_d = 1'b1;
                        end
                    end else begin
                        push      = 1'b1;
                        push_word = {remaining_q == 16'd1, uart_data};
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= IDLE;
            len_hi_q     <= 8'h00;
            remaining_q  <= 16'd0;
            pending_q    <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'h00;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            remaining_q <= remaining_d;
            pending_q   <= pending_d;
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
            if (drop) begin
                drop_count_q <= sat_inc(drop_count_q);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage only; occupancy and pointers carry all control state.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign head       = mem[rd_ptr_q];
    assign out_valid  = (count_q != '0);
    // Gating keeps the outputs at zero while empty, including after reset.
    assign out_data   = out_valid ? head[7:0] : 8'h00;
    assign out_last   = out_valid && head[8];
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Bench for uart_packet_decoder: directed packets with literal stream
// expectations plus a randomized phase, all checked every cycle against a
// queue-based packet model.
module tb_uart_packet_decoder;

    localparam int DEPTH = 4;
    localparam logic [7:0] MAGIC = 8'h55;

    logic       clock = 1'b0;
    logic       clear_n = 1'b0;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       out_valid, out_last, overflow;
    logic [7:0] out_data, drop_count;
    logic       out_ready = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    bit toggle_rdy = 0;
    bit rnd_rdy = 0;

    uart_packet_decoder #(.FIFO_DEPTH(DEPTH), .MAGIC(MAGIC)) dut (
        .clock(clock), .clear_n(clear_n), .uart_valid(uart_valid), .uart_data(uart_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_phase;      // 0 wait magic, 1 want len hi, 2 want len lo, 3 payload
    int         m_len_hi;
    int         m_rem;
    bit         m_pend;
    bit         m_ovf;
    int         m_drops;
    logic [8:0] m_q[$];

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_phase = 0; m_len_hi = 0; m_rem = 0; m_pend = 0; m_ovf = 0; m_drops = 0;
            m_q.delete();
        end else begin
            bit full, fil, do_pop, do_push;
            logic [8:0] ent;
            int len;
            full = (m_q.size() == DEPTH);
            fil = m_pend && !full;
            do_pop = (m_q.size() != 0) && out_ready;
            do_push = 0;
            ent = 9'h000;
            if (fil) begin do_push = 1; ent = 9'h100; m_pend = 0; end
            if (uart_valid) begin
                if (fil) m_ovf = 1;
                if (m_phase == 3) begin
                    if (fil || full) begin
                        m_ovf = 1;
                        if (m_rem == 1) m_pend = 1;
                    end else begin
                        do_push = 1;
                        ent = {(m_rem == 1), uart_data};
                    end
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_phase = 0;
                end else if (!fil) begin
                    if (m_phase == 0) begin
                        if (uart_data == MAGIC) m_phase = 1;
                        else if (m_drops < 255) m_drops++;
                    end else if (m_phase == 1) begin
                        m_len_hi = uart_data; m_phase = 2;
                    end else begin
                        len = m_len_hi * 256 + int'(uart_data);
                        if (len == 0) begin
                            m_phase = 0;
                            if (m_drops < 255) m_drops++;
                        end else begin
                            m_rem = len; m_phase = 3;
                        end
                    end
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(ent);
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (clear_n) begin
            logic [8:0] h;
            h = (m_q.size() != 0) ? m_q[0] : 9'h000;
            chk("cyc_valid", out_valid, m_q.size() != 0);
            chk("cyc_data", out_data, h[7:0]);
            chk("cyc_last", out_last, h[8]);
            chk("cyc_overflow", overflow, m_ovf);
            chk("cyc_drop_count", drop_count, m_drops);
        end
    end

    // Handshake collector and stall-stability check.
    logic [8:0] got[$];
    logic [8:0] expq[$];
    bit         stalled = 0;
    logic [8:0] held;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("stall_data", out_data, held[7:0]);
                chk("stall_last", out_last, held[8]);
            end
            if (out_valid && out_ready) got.push_back({out_last, out_data});
            stalled = out_valid && !out_ready;
            held = {out_last, out_data};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clock);
        if (toggle_rdy) out_ready = !out_ready;
        else if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [7:0] b);
        step();
        uart_valid = 1'b1;
        uart_data = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            uart_valid = 1'b0;
        end
    endtask

    task automatic ex(input logic [8:0] e);
        expq.push_back(e);
    endtask

    task automatic check_stream(input string name);
        chk({name, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            if (i < got.size()) chk({name, "_entry"}, got[i], expq[i]);
        end
        got.delete();
        expq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_drop", drop_count, 0);
        clear_n = 1'b1;
        got.delete();

        // normal packet
        send(8'h55); send(8'h00); send(8'h05);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'hAA);
        idle(5);
        ex(9'h011); ex(9'h022); ex(9'h033); ex(9'h044); ex(9'h1AA);
        check_stream("normal");
        chk("normal_drop", drop_count, 0);

        // garbage and zero length
        send(8'h00); send(8'h7F); send(8'h55); send(8'h00); send(8'h00);
        send(8'h55); send(8'h00); send(8'h01); send(8'hC3);
        idle(4);
        ex(9'h1C3);
        check_stream("garbage");
        chk("garbage_drop", drop_count, 3);

        // backpressure with overflow and filler
        out_ready = 1'b0;
        send(8'h55); send(8'h00); send(8'h06);
        for (int i = 1; i <= 6; i++) send(8'(i));
        idle(2);
        chk("bp_overflow", overflow, 1);
        chk("bp_head", out_data, 8'h01);
        out_ready = 1'b1;
        idle(8);
        ex(9'h001); ex(9'h002); ex(9'h003); ex(9'h004); ex(9'h100);
        check_stream("bp");
        send(8'h55); send(8'h00); send(8'h01); send(8'h9A);
        idle(3);
        ex(9'h19A);
        check_stream("bp_next");

        // stall stability
        toggle_rdy = 1;
        send(8'h55); send(8'h00); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3);
        idle(8);
        toggle_rdy = 0;
        out_ready = 1'b1;
        idle(2);
        ex(9'h0A1); ex(9'h0B2); ex(9'h1C3);
        check_stream("stall");

        // reset mid-packet
        send(8'h55); send(8'h00); send(8'h04); send(8'h10); send(8'h20);
        @(negedge clock);
        uart_valid = 1'b0;
        clear_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_data", out_data, 0);
        chk("async_overflow", overflow, 0);
        @(negedge clock);
        clear_n = 1'b1;
        got.delete();
        send(8'h55); send(8'h00); send(8'h01); send(8'h77);
        idle(3);
        ex(9'h177);
        check_stream("after_reset");
        chk("after_reset_ovf", overflow, 0);
        chk("after_reset_drop", drop_count, 0);

        // filler collides with a new magic byte
        out_ready = 1'b0;
        send(8'h55); send(8'h00); send(8'h05);
        send(8'hE1); send(8'hE2); send(8'hE3); send(8'hE4); send(8'hE5);
        idle(1);
        chk("coll_overflow", overflow, 1);
        step(); uart_valid = 1'b0; out_ready = 1'b1;
        step(); out_ready = 1'b0; uart_valid = 1'b1; uart_data = 8'h55;
        idle(1);
        chk("coll_drop", drop_count, 0);
        chk("coll_valid", out_valid, 1);
        out_ready = 1'b1;
        send(8'h55); send(8'h00); send(8'h01); send(8'h5C);
        idle(8);
        ex(9'h0E1); ex(9'h0E2); ex(9'h0E3); ex(9'h0E4); ex(9'h100); ex(9'h15C);
        check_stream("collision");

        // drop counter saturation
        for (int i = 0; i < 300; i++) send(8'h00);
        idle(2);
        chk("drop_saturate", drop_count, 255);

        // randomized traffic, checked per cycle by the model
        rnd_rdy = 1;
        for (int p = 0; p < 60; p++) begin
            if ($urandom_range(0, 4) == 0) begin
                send(8'($urandom_range(0, 255)));
            end else begin
                int len;
                len = $urandom_range(0, 7);
                send(MAGIC); send(8'h00); send(8'(len));
                for (int i = 0; i < len; i++) begin
                    send(($urandom_range(0, 5) == 0) ? MAGIC : 8'($urandom_range(0, 255)));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
        end
        rnd_rdy = 0;
        out_ready = 1'b1;
        idle(12);
        chk("drain_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
